// File: rtl/mac_accumulator.sv
// Multiply-accumulate back end: sums a burst of signed products into a guarded accumulator, then
// presents a 2N-bit saturated result over valid/ready. Optional MAC_SUB_EN adds a per-product subtract select.
module mac_accumulator #(
    parameter int unsigned N     = 16,
    parameter int unsigned GUARD = 8,
    parameter int unsigned CW    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [2*N-1:0]    prod_data,
    input  logic              prod_last,
`ifdef MAC_SUB_EN
    input  logic              prod_sub,
`endif
    input  logic              acc_clr,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2*N-1:0]    res_data,
    output logic [CW-1:0]     res_count,
    output logic              res_sat,
    output logic              acc_ovf
);

    localparam int unsigned PW = 2 * N;
    localparam int unsigned AW = PW + GUARD;

    typedef enum logic {IDLE, DONE} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   count;

    logic            accept;
    logic [AW:0]     base_ext, prod_ext, sum;
    logic            acc_clamp, res_clamp;
    logic [AW-1:0]   acc_new;
    logic [AW-PW:0]  acc_upper;
    logic [PW-1:0]   res_new;
    logic [CW-1:0]   count_new;
    logic            ovf_new;

    assign accept = prod_valid && prod_ready;

    // Datapath: one guard bit above AW makes the sum exact, so overflow shows as a sign/guard disagreement.
    always_comb begin
        base_ext = acc_clr ? '0 : {acc[AW-1], acc};
        prod_ext = {{(GUARD + 1){prod_data[PW-1]}}, prod_data};
`ifdef MAC_SUB_EN
        sum = prod_sub ? (base_ext - prod_ext) : (base_ext + prod_ext);
`else
        sum = base_ext + prod_ext;
`endif
        acc_clamp = sum[AW] ^ sum[AW-1];
        if (acc_clamp)
            acc_new = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        else
            acc_new = sum[AW-1:0];

        acc_upper = acc_new[AW-1:PW-1];
        res_clamp = !((&acc_upper) || (~|acc_upper));
        if (res_clamp)
            res_new = acc_new[AW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
        else
            res_new = acc_new[PW-1:0];

        if (acc_clr)
            count_new = {{(CW-1){1'b0}}, 1'b1};
        else if (&count)
            count_new = count;
        else
            count_new = count + 1'b1;

        ovf_new = acc_clr ? acc_clamp : (acc_ovf | acc_clamp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && prod_last) state_next = DONE;
            DONE: if (res_ready)           state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    always_comb begin
        prod_ready = (state == IDLE);
        res_valid  = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            count     <= '0;
            acc_ovf   <= 1'b0;
            res_data  <= '0;
            res_count <= '0;
            res_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc     <= acc_new;
                        count   <= count_new;
                        acc_ovf <= ovf_new;
                        if (prod_last) begin
                            res_data  <= res_new;
                            res_count <= count_new;
                            res_sat   <= res_clamp;
                        end
                    end else if (acc_clr) begin
                        acc     <= '0;
                        count   <= '0;
                        acc_ovf <= 1'b0;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        acc     <= '0;
                        count   <= '0;
                        acc_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: vector table of single-product accepts plus hand sequences
// for saturation, backpressure in DONE, clear priority and asynchronous reset.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prod_valid;
    logic        prod_ready;
    logic [31:0] prod_data;
    logic        prod_last;
    logic        prod_sub;
    logic        acc_clr;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [7:0]  res_count;
    logic        res_sat;
    logic        acc_ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_accumulator #(.N(16), .GUARD(8), .CW(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .prod_data(prod_data),
        .prod_last(prod_last),
`ifdef MAC_SUB_EN
        .prod_sub(prod_sub),
`endif
        .acc_clr(acc_clr),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_count(res_count),
        .res_sat(res_sat),
        .acc_ovf(acc_ovf)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        clr;
        logic [31:0] exp_data;
        logic [7:0]  exp_count;
        logic        exp_sat;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
    task automatic accept(input logic [31:0] d, input logic last, input logic clr);
        prod_valid = 1'b1;
        prod_data  = d;
        prod_last  = last;
        acc_clr    = clr;
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        acc_clr    = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("hs_valid_low", {63'b0, res_valid}, 64'd0);
        chk("hs_ready_high", {63'b0, prod_ready}, 64'd1);
    endtask

    task automatic chk_result(input string tag, input logic [31:0] d, input logic [7:0] c,
                              input logic s, input logic o);
        chk({tag, "_valid"}, {63'b0, res_valid}, 64'd1);
        chk({tag, "_data"},  {32'b0, res_data},  {32'b0, d});
        chk({tag, "_count"}, {56'b0, res_count}, {56'b0, c});
        chk({tag, "_sat"},   {63'b0, res_sat},   {63'b0, s});
        chk({tag, "_ovf"},   {63'b0, acc_ovf},   {63'b0, o});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0005, 1'b0, 1'b0, 32'h0,          8'd0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFD, 1'b0, 1'b0, 32'h0,          8'd0, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0010, 1'b1, 1'b0, 32'h0000_0012, 8'd3, 1'b0, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 1'b0, 1'b0, 32'h0,          8'd0, 1'b0, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF, 1'b1, 1'b0, 32'h7FFF_FFFF, 8'd2, 1'b1, 1'b0};
        vecs[5] = '{32'h0000_0064, 1'b0, 1'b0, 32'h0,          8'd0, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0007, 1'b1, 1'b1, 32'h0000_0007, 8'd1, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 8'd1, 1'b0, 1'b0};
        vecs[8] = '{32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000, 8'd1, 1'b0, 1'b0};

        rst_n = 1'b0; prod_valid = 1'b0; prod_data = '0; prod_last = 1'b0;
        prod_sub = 1'b0; acc_clr = 1'b0; res_ready = 1'b0;
        #3;
        chk("rst_valid", {63'b0, res_valid}, 64'd0);
        chk("rst_ready", {63'b0, prod_ready}, 64'd1);
        chk("rst_data",  {32'b0, res_data}, 64'd0);
        chk("rst_count", {56'b0, res_count}, 64'd0);
        chk("rst_sat",   {63'b0, res_sat}, 64'd0);
        chk("rst_ovf",   {63'b0, acc_ovf}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            chk($sformatf("v%0d_ready", i), {63'b0, prod_ready}, 64'd1);
            accept(vecs[i].data, vecs[i].last, vecs[i].clr);
            if (vecs[i].last) begin
                chk_result($sformatf("v%0d", i), vecs[i].exp_data, vecs[i].exp_count,
                           vecs[i].exp_sat, vecs[i].exp_ovf);
                handshake();
            end else begin
                chk($sformatf("v%0d_valid", i), {63'b0, res_valid}, 64'd0);
                chk($sformatf("v%0d_ovf", i), {63'b0, acc_ovf}, {63'b0, vecs[i].exp_ovf});
            end
        end

        // 256 x -2^31 lands exactly on -2^39; the 257th overflows.
        for (int i = 1; i <= 300; i++) begin
            accept(32'h8000_0000, (i == 300), 1'b0);
            if (i == 256) chk("neg256_ovf", {63'b0, acc_ovf}, 64'd0);
            if (i == 257) chk("neg257_ovf", {63'b0, acc_ovf}, 64'd1);
        end
        chk_result("neg300", 32'h8000_0000, 8'd255, 1'b1, 1'b1);

        // Backpressure in DONE with a pending product and a clear that must be ignored.
        prod_valid = 1'b1; prod_data = 32'h0000_0003; prod_last = 1'b1; acc_clr = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_ready", c), {63'b0, prod_ready}, 64'd0);
            chk($sformatf("hold%0d_valid", c), {63'b0, res_valid}, 64'd1);
            chk($sformatf("hold%0d_data", c),  {32'b0, res_data}, 64'h8000_0000);
            chk($sformatf("hold%0d_count", c), {56'b0, res_count}, 64'd255);
            chk($sformatf("hold%0d_ovf", c),   {63'b0, acc_ovf}, 64'd1);
        end
        acc_clr = 1'b0;
        handshake();
        chk("hs_ovf_clear", {63'b0, acc_ovf}, 64'd0);
        @(posedge clk); #1;
        prod_valid = 1'b0; prod_last = 1'b0;
        chk_result("post_hs", 32'h0000_0003, 8'd1, 1'b0, 1'b0);
        handshake();

        // Clear alone in IDLE discards the partial burst.
        accept(32'h0000_0009, 1'b0, 1'b0);
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        accept(32'h0000_0001, 1'b1, 1'b0);
        chk_result("clr_idle", 32'h0000_0001, 8'd1, 1'b0, 1'b0);
        handshake();

        // Asynchronous reset mid-burst.
        accept(32'h0000_0032, 1'b0, 1'b0);
        #2; rst_n = 1'b0; #1;
        chk("rb_ready", {63'b0, prod_ready}, 64'd1);
        chk("rb_valid", {63'b0, res_valid}, 64'd0);
        chk("rb_data",  {32'b0, res_data}, 64'd0);
        chk("rb_count", {56'b0, res_count}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        accept(32'h0000_0004, 1'b1, 1'b0);
        chk_result("after_rb", 32'h0000_0004, 8'd1, 1'b0, 1'b0);
        handshake();

        // Asynchronous reset while holding a saturated result in DONE.
        accept(32'h7FFF_FFFF, 1'b0, 1'b0);
        accept(32'h7FFF_FFFF, 1'b1, 1'b0);
        chk_result("pre_rd", 32'h7FFF_FFFF, 8'd2, 1'b1, 1'b0);
        #2; rst_n = 1'b0; #1;
        chk("rd_valid", {63'b0, res_valid}, 64'd0);
        chk("rd_ready", {63'b0, prod_ready}, 64'd1);
        chk("rd_data",  {32'b0, res_data}, 64'd0);
        chk("rd_count", {56'b0, res_count}, 64'd0);
        chk("rd_sat",   {63'b0, res_sat}, 64'd0);
        chk("rd_ovf",   {63'b0, acc_ovf}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
